// File: rtl/div_seq.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EXECUTE stage.
// Latency: 1 IDLE + WIDTH BUSY stall cycles, result in DONE; div-by-zero/overflow stall 1 cycle.
// Backpressure: div_stall freezes IF/ID/EX until DONE; flush aborts any state back to IDLE.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_en_e,
    input  logic [2:0]       funct3_e,
    input  logic [WIDTH-1:0] src_a_e,
    input  logic [WIDTH-1:0] src_b_e,
    input  logic             flush,
    output logic             div_stall,
    output logic             div_valid,
    output logic [WIDTH-1:0] div_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic             is_rem_q;
    logic             sgn_a_q;
    logic             sgn_b_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] result_q;

    // Opcode bit 2 is always set for divides; it carries no information here.
    logic unused_funct3;
    assign unused_funct3 = funct3_e[2];

    logic             is_signed_in;
    logic             sgn_a_in;
    logic             sgn_b_in;
    logic [WIDTH-1:0] abs_a_in;
    logic [WIDTH-1:0] abs_b_in;
    logic             div_zero_in;
    logic             ovf_in;

    assign is_signed_in = ~funct3_e[0];
    assign sgn_a_in     = is_signed_in & src_a_e[WIDTH-1];
    assign sgn_b_in     = is_signed_in & src_b_e[WIDTH-1];
    assign abs_a_in     = sgn_a_in ? -src_a_e : src_a_e;
    assign abs_b_in     = sgn_b_in ? -src_b_e : src_b_e;
    assign div_zero_in  = (src_b_e == '0);
    assign ovf_in       = is_signed_in & (src_a_e == MIN_NEG) & (src_b_e == '1);

    // One restoring step; the shifted remainder needs WIDTH+1 bits for unsigned divisors >= 2^(WIDTH-1).
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign ge     = ~diff[WIDTH];
    assign rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], ge};
    assign q_fix  = (sgn_a_q ^ sgn_b_q) ? -quo_nx : quo_nx;
    assign r_fix  = sgn_a_q ? -rem_nx : rem_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            is_rem_q <= 1'b0;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_en_e) begin
                        is_rem_q <= funct3_e[1];
                        sgn_a_q  <= sgn_a_in;
                        sgn_b_q  <= sgn_b_in;
                        quo_q    <= abs_a_in;
                        dvs_q    <= abs_b_in;
                        rem_q    <= '0;
                        count_q  <= '0;
                        if (div_zero_in) begin
                            result_q <= funct3_e[1] ? src_a_e : '1;
                            state_q  <= DONE;
                        end else if (ovf_in) begin
                            result_q <= funct3_e[1] ? '0 : src_a_e;
                            state_q  <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q   <= rem_nx;
                    quo_q   <= quo_nx;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH-1)) begin
                        result_q <= is_rem_q ? r_fix : q_fix;
                        state_q  <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall is raised combinationally in IDLE so the front end freezes in the accept cycle.
    assign div_stall  = rst_n & ~flush & (((state_q == IDLE) & div_en_e) | (state_q == BUSY));
    assign div_valid  = (state_q == DONE) & ~flush;
    assign div_result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a driver issues divides and queues expected results, a monitor checks each div_valid.
module tb_div_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         div_en_e = 1'b0;
    logic [2:0]   funct3_e = 3'b000;
    logic [W-1:0] src_a_e = '0;
    logic [W-1:0] src_b_e = '0;
    logic         flush = 1'b0;
    logic         div_stall;
    logic         div_valid;
    logic [W-1:0] div_result;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    div_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_en_e   (div_en_e),
        .funct3_e   (funct3_e),
        .src_a_e    (src_a_e),
        .src_b_e    (src_b_e),
        .flush      (flush),
        .div_stall  (div_stall),
        .div_valid  (div_valid),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_head;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every div_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (div_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got div_result %h with no divide pending", div_result);
            end else begin
                exp_head = exp_q.pop_front();
                check("result", div_result, exp_head);
            end
        end
    end

    // Hold the instruction in EX until DONE, counting stall cycles; leaves inputs live for back-to-back issue.
    task automatic run_div(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_stall);
        int stalls;
        bit got;
        exp_q.push_back(exp);
        funct3_e = f3;
        src_a_e  = a;
        src_b_e  = b;
        div_en_e = 1'b1;
        stalls   = 0;
        got      = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (div_stall === 1'b1) stalls++;
            if (div_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got no div_valid within 100 cycles, required one", name);
            void'(exp_q.pop_back());
        end
        check({name, "_stall"}, W'(stalls), W'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    // Start a normal divide and stop with the FSM in BUSY at count=10.
    task automatic start_to_count10(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        funct3_e = f3;
        src_a_e  = a;
        src_b_e  = b;
        div_en_e = 1'b1;
        repeat (11) @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        div_en_e = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with div_en_e asserted to show stall is masked by reset.
        div_en_e = 1'b1;
        #2;
        check("reset_stall", {31'b0, div_stall}, 32'd0);
        check("reset_valid", {31'b0, div_valid}, 32'd0);
        check("reset_result", div_result, 32'd0);
        div_en_e = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_div("divu_100_7",  F_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_div("remu_100_7",  F_REMU, 32'd100, 32'd7, 32'd2,  33);
        run_div("div_m7_2",    F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_div("rem_m7_2",    F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_div("div_7_m2",    F_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_div("rem_7_m2",    F_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_div("div_5_0",     F_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_div("remu_5_0",    F_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_div("rem_m5_0",    F_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        run_div("div_ovf",     F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_div("rem_ovf",     F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_div("divu_ovfpat", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_div("remu_ovfpat", F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_div("divu_big",    F_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
        run_div("remu_big",    F_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
        run_div("div_m100_m7", F_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);
        idle_cycles(2);

        // Back-to-back: second divide enters EX right after the first DONE.
        run_div("b2b_first",  F_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_div("b2b_second", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        idle_cycles(2);

        // Asynchronous reset in the middle of BUSY.
        start_to_count10(F_DIVU, 32'd1000, 32'd3);
        check("busy_stall", {31'b0, div_stall}, 32'd1);
        rst_n    = 1'b0;
        div_en_e = 1'b0;
        #1;
        check("midrst_stall", {31'b0, div_stall}, 32'd0);
        check("midrst_valid", {31'b0, div_valid}, 32'd0);
        check("midrst_result", div_result, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_div("after_rst", F_REMU, 32'd1000, 32'd3, 32'd1, 33);

        // Flush in the middle of BUSY: no result, then a clean divide.
        start_to_count10(F_DIVU, 32'd100, 32'd7);
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'b0, div_stall}, 32'd0);
        check("flush_valid", {31'b0, div_valid}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle_cycles(40);
        run_div("after_flush", F_DIVU, 32'd100, 32'd7, 32'd14, 33);
        idle_cycles(3);

        check("queue_empty", W'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
